// File: rtl/ntt_poly_mult_ctrl.sv
// ntt_poly_mult_ctrl: load / compute / unload sequencer around a combinational NTT multiplier core.
// Define NTT_CTRL_PERF_EN to add a saturating 16-bit job_count output.
module ntt_poly_mult_ctrl #(
  parameter int N      = 17,
  parameter int D      = 8,
  parameter int SETTLE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D-1:0]   in_data,
  output logic [D*N-1:0] core_a,
  output logic [D*N-1:0] core_b,
  input  logic [D*N-1:0] core_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D-1:0]   out_data,
  output logic           out_last,
`ifdef NTT_CTRL_PERF_EN
  output logic [15:0]    job_count,
`endif
  output logic           busy
);

  localparam int IW = $clog2(2 * N);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_UNLD = 2'd2;

  localparam logic [IW-1:0] LAST_W = IW'(2 * N - 1);
  localparam logic [IW-1:0] LAST_O = IW'(N - 1);
  localparam logic [IW-1:0] NW     = IW'(N);
  localparam logic [IW-1:0] ONE    = IW'(1);
  localparam logic [7:0]    SET0   = 8'(SETTLE);

  logic [1:0]     state_q;
  logic [IW-1:0]  idx_q;
  logic [7:0]     cnt_q;
  logic [D*N-1:0] a_q;
  logic [D*N-1:0] b_q;
  logic [D*N-1:0] res_q;

  logic          st_load;
  logic          st_comp;
  logic          st_unld;
  logic          in_hs;
  logic          out_hs;
  logic          ld_a;
  logic [IW-1:0] b_idx;

  assign st_load = (state_q == S_LOAD);
  assign st_comp = (state_q == S_COMP);
  assign st_unld = (state_q == S_UNLD);

  // rst_n gates in_ready so nothing is offered while reset is held
  assign in_ready  = rst_n & st_load;
  assign in_hs     = in_valid & in_ready;
  assign out_valid = st_unld;
  assign out_hs    = out_valid & out_ready;
  assign ld_a      = (idx_q < NW);
  assign b_idx     = idx_q - NW;

  assign core_a = a_q;
  assign core_b = b_q;

  assign out_data = st_unld ? res_q[int'(idx_q)*D +: D] : '0;
  assign out_last = st_unld & (idx_q == LAST_O);
  assign busy     = st_comp | st_unld | (st_load & (idx_q != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      unique case (1'b1)
        st_load: begin
          if (in_hs) begin
            if (ld_a) a_q[int'(idx_q)*D +: D] <= in_data;
            else      b_q[int'(b_idx)*D +: D] <= in_data;
            if (idx_q == LAST_W) begin
              state_q <= S_COMP;
              idx_q   <= '0;
              cnt_q   <= SET0;
            end else begin
              idx_q <= idx_q + ONE;
            end
          end
        end
        st_comp: begin
          cnt_q <= cnt_q - 8'd1;
          // core has had SETTLE cycles of stable operands at this edge
          if (cnt_q == 8'd1) begin
            res_q   <= core_c;
            state_q <= S_UNLD;
            idx_q   <= '0;
          end
        end
        st_unld: begin
          if (out_hs) begin
            if (idx_q == LAST_O) begin
              state_q <= S_LOAD;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + ONE;
            end
          end
        end
        default: begin
          state_q <= S_LOAD;
          idx_q   <= '0;
        end
      endcase
    end
  end

`ifdef NTT_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_count <= '0;
    end else if (out_hs && out_last && job_count != 16'hFFFF) begin
      job_count <= job_count + 16'd1;
    end
  end
`endif

endmodule
